// File: rtl/panda_pkg.sv
// Shared types and constants for the panda fetch front end.
package panda_pkg;

  localparam int unsigned XLen = 32;

  // Canonical NOP (addi x0, x0, 0); shown in IF/ID whenever it holds no instruction.
  localparam logic [XLen-1:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    IfIdle = 2'd0,
    IfReq  = 2'd1,
    IfWait = 2'd2,
    IfHold = 2'd3
  } if_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLen-1:0] instr;
    logic [XLen-1:0] pc;
    logic [XLen-1:0] pc_inc;
  } if_id_t;

endpackage

// File: rtl/panda_if_id_reg.sv
// IF/ID pipeline register. Priority: flush > load > drain (consumer took it) > hold.
// Optional macro PANDA_IF_MISALIGN_CHECK_EN adds a misaligned-fetch flag field.
module panda_if_id_reg
  import panda_pkg::*;
#(
  parameter int unsigned     Width      = 32,
  parameter logic [Width-1:0] ResetInstr = NopInstr
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic [Width-1:0] instr_i,
  input  logic [Width-1:0] pc_i,
  input  logic [Width-1:0] pc_inc_i,
`ifdef PANDA_IF_MISALIGN_CHECK_EN
  input  logic             misaligned_i,
  output logic             misaligned_o,
`endif
  output logic             valid_o,
  output logic [Width-1:0] instr_o,
  output logic [Width-1:0] pc_o,
  output logic [Width-1:0] pc_inc_o
);

  // Register update: kill on flush, capture on load, empty once decode consumes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      instr_o  <= ResetInstr;
      pc_o     <= '0;
      pc_inc_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      instr_o <= ResetInstr;
    end else if (load_i) begin
      valid_o  <= 1'b1;
      instr_o  <= instr_i;
      pc_o     <= pc_i;
      pc_inc_o <= pc_inc_i;
    end else if (valid_o && !stall_i) begin
      valid_o <= 1'b0;
      instr_o <= ResetInstr;
    end
  end

`ifdef PANDA_IF_MISALIGN_CHECK_EN
  // Misaligned flag follows the same priority as the valid bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misaligned_o <= 1'b0;
    end else if (flush_i) begin
      misaligned_o <= 1'b0;
    end else if (load_i) begin
      misaligned_o <= misaligned_i;
    end else if (valid_o && !stall_i) begin
      misaligned_o <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/panda_if_stage.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch, captured into IF/ID.
// Optional macro PANDA_IF_MISALIGN_CHECK_EN: misaligned pc_i skips memory and
// loads a flagged NOP into IF/ID instead of masking the low address bits.
//
// Memory handshake: a request is accepted in the cycle imem_req_o && imem_gnt_i;
// its single response arrives in a later cycle with imem_rvalid_i. rvalid seen
// outside WAIT belongs to no request of ours and is ignored.
module panda_if_stage
  import panda_pkg::*;
#(
  parameter int unsigned      Width      = 32,
  parameter logic [Width-1:0] ResetInstr = NopInstr
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] pc_i,
  input  logic [Width-1:0] pc_inc_i,
  input  logic             flush_i,
  input  logic             id_stall_i,
  output logic             pc_stall_o,
  output logic             imem_req_o,
  output logic [Width-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [Width-1:0] imem_rdata_i,
  output logic             if_id_valid_o,
  output logic [Width-1:0] if_id_instr_o,
  output logic [Width-1:0] if_id_pc_o,
  output logic [Width-1:0] if_id_pc_inc_o,
`ifdef PANDA_IF_MISALIGN_CHECK_EN
  output logic             if_id_misaligned_o,
`endif
  output if_state_e        dbg_state_o
);

  if_state_e        state_q, state_d;
  logic             discard_q, discard_d;
  logic [Width-1:0] pend_pc_q, pend_pc_d;
  logic [Width-1:0] pend_pc_inc_q, pend_pc_inc_d;
  logic [Width-1:0] pend_instr_q, pend_instr_d;

  logic             ifid_free;
  logic             misaligned;
  logic             load;
  logic [Width-1:0] load_instr, load_pc, load_pc_inc;

  assign ifid_free   = !id_stall_i || !if_id_valid_o;
  assign imem_addr_o = {pc_i[Width-1:2], 2'b00};
  assign dbg_state_o = state_q;

`ifdef PANDA_IF_MISALIGN_CHECK_EN
  logic load_mis;
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  logic unused_pc_low;
  assign unused_pc_low = ^pc_i[1:0];
  assign misaligned    = 1'b0;
`endif

  // State, discard flag and pending fetch registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IfIdle;
      discard_q     <= 1'b0;
      pend_pc_q     <= '0;
      pend_pc_inc_q <= '0;
      pend_instr_q  <= ResetInstr;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      pend_pc_q     <= pend_pc_d;
      pend_pc_inc_q <= pend_pc_inc_d;
      pend_instr_q  <= pend_instr_d;
    end
  end

  // Next-state logic: flush beats every load path.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    pend_pc_d     = pend_pc_q;
    pend_pc_inc_d = pend_pc_inc_q;
    pend_instr_d  = pend_instr_q;
    unique case (state_q)
      IfIdle: state_d = IfReq;
      IfReq: begin
        if (!misaligned && imem_gnt_i) begin
          state_d       = IfWait;
          pend_pc_d     = pc_i;
          pend_pc_inc_d = pc_inc_i;
          discard_d     = flush_i;
        end
      end
      IfWait: begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          if (discard_q || flush_i || ifid_free) begin
            state_d = IfReq;
          end else begin
            pend_instr_d = imem_rdata_i;
            state_d      = IfHold;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      IfHold: begin
        if (flush_i || !id_stall_i) state_d = IfReq;
      end
      default: state_d = IfIdle;
    endcase
  end

  // Outputs: memory request, IF/ID load select and PC back-pressure.
  always_comb begin
    imem_req_o  = 1'b0;
    load        = 1'b0;
    load_instr  = imem_rdata_i;
    load_pc     = pend_pc_q;
    load_pc_inc = pend_pc_inc_q;
`ifdef PANDA_IF_MISALIGN_CHECK_EN
    load_mis    = 1'b0;
`endif
    unique case (state_q)
      IfReq: begin
        if (misaligned) begin
          load        = ifid_free;
          load_instr  = ResetInstr;
          load_pc     = pc_i;
          load_pc_inc = pc_inc_i;
`ifdef PANDA_IF_MISALIGN_CHECK_EN
          load_mis    = 1'b1;
`endif
        end else begin
          imem_req_o = 1'b1;
        end
      end
      IfWait: load = imem_rvalid_i && !discard_q && ifid_free;
      IfHold: begin
        load       = !id_stall_i;
        load_instr = pend_instr_q;
      end
      default: load = 1'b0;
    endcase
    if (flush_i) load = 1'b0;
    // During a flush the PC must load its redirect target, so never stall it.
    pc_stall_o = flush_i ? 1'b0 : !load;
  end

  panda_if_id_reg #(
    .Width     (Width),
    .ResetInstr(ResetInstr)
  ) u_if_id_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .flush_i     (flush_i),
    .stall_i     (id_stall_i),
    .instr_i     (load_instr),
    .pc_i        (load_pc),
    .pc_inc_i    (load_pc_inc),
`ifdef PANDA_IF_MISALIGN_CHECK_EN
    .misaligned_i(load_mis),
    .misaligned_o(if_id_misaligned_o),
`endif
    .valid_o     (if_id_valid_o),
    .instr_o     (if_id_instr_o),
    .pc_o        (if_id_pc_o),
    .pc_inc_o    (if_id_pc_inc_o)
  );

endmodule

// File: tb/tb_panda_if_stage.sv
// Bench for panda_if_stage: directed scenarios plus a randomized run against
// a behavioural PC / memory / decode model.
module tb_panda_if_stage;
  import panda_pkg::*;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] pc_i = '0, pc_inc_i = '0;
  logic        flush_i = 1'b0, id_stall_i = 1'b0;
  logic        pc_stall_o, imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o, if_id_pc_o, if_id_pc_inc_o;
`ifdef PANDA_IF_MISALIGN_CHECK_EN
  logic        if_id_misaligned_o;
`endif
  if_state_e   dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  panda_if_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .pc_inc_i(pc_inc_i),
    .flush_i(flush_i), .id_stall_i(id_stall_i), .pc_stall_o(pc_stall_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_id_valid_o(if_id_valid_o), .if_id_instr_o(if_id_instr_o),
    .if_id_pc_o(if_id_pc_o), .if_id_pc_inc_o(if_id_pc_inc_o),
`ifdef PANDA_IF_MISALIGN_CHECK_EN
    .if_id_misaligned_o(if_id_misaligned_o),
`endif
    .dbg_state_o(dbg_state)
  );

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid_o); end
    checks++; if (if_id_instr_o !== Nop) begin errors++; $display("FAIL reset_instr: got %h want %h", if_id_instr_o, Nop); end
    checks++; if (if_id_pc_o !== 32'h0 || if_id_pc_inc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h/%h want 0/0", if_id_pc_o, if_id_pc_inc_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++; if (pc_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b want 1", pc_stall_o); end
    checks++; if (dbg_state !== IfIdle) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic_fetch();
    @(negedge clk_i); pc_i = 32'h0; pc_inc_i = 32'h4; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL basic_req: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
    checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL basic_stall_pulse: got %b want 0", pc_stall_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; pc_i = 32'h4; pc_inc_i = 32'h8; #1;
    checks++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h0050_0093) begin errors++; $display("FAIL basic_capture: got v=%b instr=%h want 1/00500093", if_id_valid_o, if_id_instr_o); end
    checks++; if (if_id_pc_o !== 32'h0 || if_id_pc_inc_o !== 32'h4) begin errors++; $display("FAIL basic_pc: got %h/%h want 0/4", if_id_pc_o, if_id_pc_inc_o); end
    checks++; if (pc_stall_o !== 1'b1) begin errors++; $display("FAIL basic_stall_after: got %b want 1", pc_stall_o); end
  endtask

  task automatic test_slow_memory();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || pc_stall_o !== 1'b1) begin errors++; $display("FAIL slow_req_cycle%0d: got req=%b addr=%h stall=%b want 1/4/1", i, imem_req_o, imem_addr_o, pc_stall_o); end
      if (i == 3) imem_gnt_i = 1'b1;
      @(negedge clk_i); imem_gnt_i = 1'b0; #1;
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin errors++; $display("FAIL slow_wait_cycle%0d: got req=%b stall=%b want 0/1", i, imem_req_o, pc_stall_o); end
      checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== Nop) begin errors++; $display("FAIL slow_drained%0d: got v=%b instr=%h want 0/nop", i, if_id_valid_o, if_id_instr_o); end
      @(negedge clk_i);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0020_8113; #1;
    checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL slow_stall_pulse: got %b want 0", pc_stall_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; pc_i = 32'h8; pc_inc_i = 32'hC; #1;
    checks++; if (if_id_instr_o !== 32'h0020_8113 || if_id_pc_o !== 32'h4 || if_id_pc_inc_o !== 32'h8) begin errors++; $display("FAIL slow_capture: got %h@%h/%h want 00208113@4/8", if_id_instr_o, if_id_pc_o, if_id_pc_inc_o); end
  endtask

  task automatic test_flush();
    imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; flush_i = 1'b1; #1;
    checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", pc_stall_o); end
    @(negedge clk_i); flush_i = 1'b0; pc_i = 32'h100; pc_inc_i = 32'h104;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
    checks++; if (pc_stall_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL flush_drop_cycle: got stall=%b req=%b want 1/0", pc_stall_o, imem_req_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
    checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== Nop) begin errors++; $display("FAIL flush_ifid: got v=%b instr=%h want 0/nop", if_id_valid_o, if_id_instr_o); end
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL flush_redirect: got req=%b addr=%h want 1/100", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_decode_stall();
    id_stall_i = 1'b1; imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0513; #1;
    checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL stall_empty_load: got %b want 0", pc_stall_o); end
    @(negedge clk_i); imem_rvalid_i = 1'b0; pc_i = 32'h104; pc_inc_i = 32'h108; imem_gnt_i = 1'b1; #1;
    @(negedge clk_i); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113; #1;
    checks++; if (pc_stall_o !== 1'b1) begin errors++; $display("FAIL stall_no_capture: got %b want 1", pc_stall_o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
      checks++; if (dbg_state !== IfHold || imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got state=%0d req=%b stall=%b want HOLD/0/1", i, dbg_state, imem_req_o, pc_stall_o); end
      checks++; if (if_id_instr_o !== 32'h0000_0513 || if_id_pc_o !== 32'h100) begin errors++; $display("FAIL stall_ifid_held%0d: got %h@%h want 00000513@100", i, if_id_instr_o, if_id_pc_o); end
    end
    @(negedge clk_i); id_stall_i = 1'b0; #1;
    checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL stall_release_pulse: got %b want 0", pc_stall_o); end
    @(negedge clk_i); pc_i = 32'h108; pc_inc_i = 32'h10C; #1;
    checks++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h00A0_0113 || if_id_pc_o !== 32'h104 || if_id_pc_inc_o !== 32'h108) begin errors++; $display("FAIL stall_release_load: got v=%b %h@%h/%h want 1 00a00113@104/108", if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc_inc_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_next_req: got %b want 1", imem_req_o); end
  endtask

  task automatic test_reset_mid_fetch();
    imem_gnt_i = 1'b1;
    @(negedge clk_i); imem_gnt_i = 1'b0; #1;
    checks++; if (dbg_state !== IfWait) begin errors++; $display("FAIL rstmid_in_wait: got %0d want WAIT", dbg_state); end
    rst_ni = 1'b0; #1;
    checks++; if (if_id_valid_o !== 1'b0 || imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin errors++; $display("FAIL rstmid_async: got v=%b req=%b stall=%b want 0/0/1", if_id_valid_o, imem_req_o, pc_stall_o); end
    @(negedge clk_i); rst_ni = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    @(negedge clk_i); imem_rvalid_i = 1'b0; #1;
    checks++; if (dbg_state !== IfReq) begin errors++; $display("FAIL rstmid_state: got %0d want REQ", dbg_state); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_ignored%0d: got v=%b want 0", i, if_id_valid_o); end
      @(negedge clk_i); #1;
    end
  endtask

`ifdef PANDA_IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    pc_i = 32'h6; pc_inc_i = 32'hA; #1;
    checks++; if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b0) begin errors++; $display("FAIL mis_noreq: got req=%b stall=%b want 0/0", imem_req_o, pc_stall_o); end
    @(negedge clk_i); pc_i = 32'h200; pc_inc_i = 32'h204; #1;
    checks++; if (if_id_valid_o !== 1'b1 || if_id_misaligned_o !== 1'b1 || if_id_pc_o !== 32'h6 || if_id_instr_o !== Nop) begin errors++; $display("FAIL mis_ifid: got v=%b m=%b pc=%h instr=%h want 1/1/6/nop", if_id_valid_o, if_id_misaligned_o, if_id_pc_o, if_id_instr_o); end
    @(negedge clk_i); #1;
  endtask
`endif

  // Random traffic: model PC advances on each non-stall cycle, redirects on flush;
  // the decode side must see exactly the PC sequence with memory contents.
  task automatic test_random();
    logic [31:0] model_pc = 32'h200;
    logic        out = 1'b0;
    logic [31:0] raddr = '0;
    int          dly = 0;
    int          consumed = 0;
    logic        flush;
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      flush = ($urandom_range(0, 39) == 0);
      target = 32'($urandom_range(0, 1023)) << 2;
      flush_i = flush;
      id_stall_i = ($urandom_range(0, 2) == 0);
      pc_i = model_pc; pc_inc_i = model_pc + 32'h4;
      imem_gnt_i = 1'b0;
      if (out && dly == 0) begin
        imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(raddr);
      end else if (!out && $urandom_range(0, 9) == 0) begin
        imem_rvalid_i = 1'b1; imem_rdata_i = $urandom;
      end else begin
        imem_rvalid_i = 1'b0;
      end
      #1;
      if (imem_req_o) begin
        checks++; if (out || imem_addr_o !== model_pc) begin errors++; $display("FAIL rand_req cyc%0d: got addr=%h outstanding=%b want %h/0", cyc, imem_addr_o, out, model_pc); end
        imem_gnt_i = 1'($urandom_range(0, 1));
      end
      #1;
      if (flush) begin
        checks++; if (pc_stall_o !== 1'b0) begin errors++; $display("FAIL rand_flush_stall cyc%0d: got %b want 0", cyc, pc_stall_o); end
      end
      if (if_id_valid_o && !id_stall_i && !flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_consume cyc%0d: got pc=%h, nothing expected", cyc, if_id_pc_o);
        end else begin
          exp_pc = exp_q.pop_front();
          consumed++;
          if (if_id_pc_o !== exp_pc || if_id_pc_inc_o !== exp_pc + 32'h4 || if_id_instr_o !== mem_word(exp_pc)) begin
            errors++; $display("FAIL rand_consume cyc%0d: got %h@%h/%h want %h@%h", cyc, if_id_instr_o, if_id_pc_o, if_id_pc_inc_o, mem_word(exp_pc), exp_pc);
          end
        end
      end
      if (imem_rvalid_i && out) out = 1'b0;
      else if (out) dly--;
      if (imem_req_o && imem_gnt_i) begin
        out = 1'b1; raddr = imem_addr_o; dly = int'($urandom_range(0, 3));
      end
      if (flush) begin
        exp_q.delete(); model_pc = target;
      end else if (!pc_stall_o) begin
        exp_q.push_back(model_pc); model_pc = model_pc + 32'h4;
      end
    end
    checks++; if (consumed < 100) begin errors++; $display("FAIL rand_progress: got %0d consumed want >=100", consumed); end
    @(negedge clk_i); flush_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0; id_stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_slow_memory();
    test_flush();
    test_decode_stall();
    test_reset_mid_fetch();
`ifdef PANDA_IF_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/panda_if_stage.md
Name: panda_if_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current fetch address and its +4 value from the PC block, and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Captures each returned instruction into the IF/ID pipeline register.
- Back-pressures the PC (stall) until the instruction is captured, and drops in-flight fetches on flush (branch/jump redirect).

Parameters:
- Width, 32, address/data width in bits.
- ResetInstr, 32'h0000_0013, instruction presented on if_id_instr_o when invalid (NOP).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- pc_i  input  Width  fetch address from PC block
- pc_inc_i  input  Width  pc_i+4 from PC block
- flush_i  input  1  redirect taken; kill IF/ID and any outstanding fetch
- id_stall_i  input  1  decode cannot accept; hold IF/ID
- pc_stall_o  output  1  to PC stall input; PC holds while 1
- imem_req_o  output  1  memory request
- imem_addr_o  output  Width  request address, word aligned
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response data valid
- imem_rdata_i  input  Width  response instruction
- if_id_valid_o  output  1  IF/ID holds a valid instruction
- if_id_instr_o  output  Width  fetched instruction
- if_id_pc_o  output  Width  address of fetched instruction
- if_id_pc_inc_o  output  Width  address+4

Behaviour:
- Reset values: state IDLE; if_id_valid_o 0; if_id_instr_o ResetInstr; if_id_pc_o and if_id_pc_inc_o 0; discard flag 0; imem_req_o 0; pc_stall_o 1.
- At most one outstanding request.
- FSM states:
  - IDLE: go to REQ next cycle.
  - REQ: imem_req_o=1, imem_addr_o={pc_i[Width-1:2],2'b00} (combinational, so a same-cycle redirect on pc_i is honoured). On imem_gnt_i, latch pc_i/pc_inc_i into a pending register and go to WAIT.
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - discard flag set: drop the data, clear the flag, go to REQ.
    - IF/ID free (id_stall_i=0 or if_id_valid_o=0): load IF/ID with rdata and pending pc/pc_inc, set valid, go to REQ.
    - otherwise: hold the data in the pending register and go to HOLD.
  - HOLD: when id_stall_i=0, load IF/ID from pending and go to REQ.
- pc_stall_o = 0 only in the cycle an instruction is loaded into IF/ID without discard; 1 in every other cycle. The PC therefore advances exactly once per captured instruction.
- IF/ID with valid and id_stall_i=1: all IF/ID fields hold.
- IF/ID with valid, id_stall_i=0 and no load this cycle: valid clears, instr becomes ResetInstr.
- flush_i (has priority over loads):
  - IF/ID valid clears and instr becomes ResetInstr.
  - In WAIT with rvalid not present this cycle: set the discard flag.
  - In WAIT with rvalid present this cycle: drop the data and go to REQ.
  - In HOLD: drop the pending data and go to REQ.
  - In REQ with gnt this cycle: go to WAIT with discard set.
  - pc_stall_o is forced 0 during flush so the PC loads the redirect target.
- imem_rvalid_i outside WAIT: ignored.
- Reset mid-transaction: all state clears; the late response is ignored because state is IDLE.
- Address arithmetic: pc_inc_i is passed through unmodified; no arithmetic in this block.

Optional Feature:
- Macro: PANDA_IF_MISALIGN_CHECK_EN.
- Defined:
  - Adds output if_id_misaligned_o (1 bit, reset 0).
  - If pc_i[1:0]!=0 in REQ, no memory request is issued.
  - IF/ID is loaded next with valid=1, misaligned=1, instr=ResetInstr, and the state returns to REQ.
- Undefined: no port; the low address bits are silently masked.

Decomposition:
- panda_pkg holds:
  - typedef if_state_e {IfIdle, IfReq, IfWait, IfHold};
  - constant NopInstr = 32'h0000_0013 (ResetInstr default);
  - struct if_id_t {valid, instr, pc, pc_inc}.
- One sub-module is natural: panda_if_id_reg, the IF/ID pipeline register with load/hold/flush controls, reusable for other stage boundaries.

Test Plan:
- Reset, then pc_i=0x0, gnt in the same cycle, rvalid one cycle later with 0x00500093 -> if_id_instr_o=0x00500093, if_id_pc_o=0x0, if_id_pc_inc_o=0x4, one-cycle pc_stall_o=0.
- gnt delayed 3 cycles, rvalid delayed 2 more -> imem_req_o held 1 for 4 cycles, address stable, pc_stall_o=1 throughout until capture.
- flush_i in WAIT, then rvalid with 0xDEADBEEF -> data dropped, if_id_valid_o=0, next request uses redirected pc_i=0x100.
- id_stall_i=1 while rvalid arrives with 0x00A00113 -> HOLD, no new request; release -> IF/ID loads 0x00A00113, pc_stall_o pulses 0.
- Assert rst_ni low while in WAIT, then rvalid after release -> response ignored, if_id_valid_o stays 0.
- With PANDA_IF_MISALIGN_CHECK_EN defined, pc_i=0x6 -> no imem_req_o, if_id_misaligned_o=1, if_id_pc_o=0x6.
